// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
//   CP0 exception / interrupt controller for the pipelined MIPS core.
//   Arbitrates MEM-stage synchronous exceptions, external interrupts and
//   ERET. Owns the Cause and EPC registers and drives the Status next-value
//   bus, the pipeline flush and the PC redirect. Also provides the mfc0
//   read mux.
//
// Ports
//   clk          system clock, all state updates on posedge
//   rst          asynchronous, active-low reset
//   status_q     current Status (IE=[0], EXL=[1], ERL=[2], IM=[15:8])
//   status_d     next Status value (mirrors status_q unless an event fires)
//   status_fwd   Status load strobe for this edge
//   hw_int       asynchronous external interrupt lines
//   exc_req      MEM-stage synchronous exception request
//   exc_code     ExcCode for exc_req
//   exc_pc       PC of the MEM-stage instruction
//   exc_bd       MEM-stage instruction sits in a delay slot
//   mem_valid    MEM stage holds a valid, interruptible instruction
//   eret         MEM-stage ERET
//   mtc0_we      mtc0 write enable
//   cp0_addr     mtc0/mfc0 register number (12 Status, 13 Cause, 14 EPC)
//   mtc0_data    mtc0 write data
//   mfc0_data    mfc0 read data (combinational)
//   cause_q      Cause register
//   epc_q        EPC register
//   flush        flush IF..MEM (high for the single FLUSH cycle)
//   redirect     PC redirect valid (high for the single FLUSH cycle)
//   redirect_pc  PC redirect target
//
// Handshake: there is no back-pressure. An event is accepted in the cycle
// it is presented while the controller is IDLE (status_fwd marks the
// accept); flush/redirect follow for exactly one cycle. Requests presented
// during that FLUSH cycle are dropped, never queued.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         status_q,
  output logic [31:0]         status_d,
  output logic                status_fwd,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                exc_req,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_bd,
  input  logic                mem_valid,
  input  logic                eret,
  input  logic                mtc0_we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         mtc0_data,
  output logic [31:0]         mfc0_data,
  output logic [31:0]         cause_q,
  output logic [31:0]         epc_q,
  output logic                flush,
  output logic                redirect,
  output logic [31:0]         redirect_pc
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [HW_INT_W-1:0] sync1_q, sync2_q;
  logic                bd_q;
  logic [1:0]          ip_sw_q;
  logic [4:0]          code_q;
  logic [31:0]         epc_r;
  logic [31:0]         redir_pc_r;

  logic [7:0] ip;
  logic       int_pend;
  logic       idle;
  logic       take_exc, take_int, take_eret, entry;
  logic       cause_we, epc_we;

  // Cause.IP: software bits [1:0] from mtc0, hardware bits from the
  // synchronizer output, refreshed every cycle.
  always_comb begin
    ip = '0;
    ip[1:0] = ip_sw_q;
    ip[2 +: HW_INT_W] = sync2_q;
  end

  assign cause_q = {bd_q, 15'b0, ip, 1'b0, code_q, 2'b00};
  assign epc_q   = epc_r;

  assign int_pend = (|(ip & status_q[15:8])) & status_q[0] & ~status_q[1] & ~status_q[2];

  // Priority: exception > interrupt (only on a valid MEM instr) > ERET.
  assign idle      = (state_q == IDLE);
  assign take_exc  = idle & exc_req;
  assign take_int  = idle & ~exc_req & int_pend & mem_valid;
  assign take_eret = idle & ~exc_req & ~(int_pend & mem_valid) & eret;
  assign entry     = take_exc | take_int;

  assign cause_we = mtc0_we & (cp0_addr == ADDR_CAUSE);
  assign epc_we   = mtc0_we & (cp0_addr == ADDR_EPC);

  // Next-state and Status next-value. Status reloads D every cycle, so D
  // must mirror Q whenever nothing is accepted.
  always_comb begin
    state_d    = IDLE;
    status_d   = status_q;
    status_fwd = 1'b0;
    if (entry) begin
      state_d    = FLUSH;
      status_fwd = 1'b1;
      status_d   = status_q | 32'h0000_0002;
    end else if (take_eret) begin
      state_d    = FLUSH;
      status_fwd = 1'b1;
      // ERL takes precedence over EXL on return.
      if (status_q[2]) status_d = status_q & ~32'h0000_0004;
      else             status_d = status_q & ~32'h0000_0002;
    end
  end

  always_comb begin
    mfc0_data = '0;
    case (cp0_addr)
      ADDR_STATUS: mfc0_data = status_q;
      ADDR_CAUSE:  mfc0_data = cause_q;
      ADDR_EPC:    mfc0_data = epc_r;
      default:     mfc0_data = '0;
    endcase
  end

  assign flush       = (state_q == FLUSH);
  assign redirect    = (state_q == FLUSH);
  assign redirect_pc = redir_pc_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      code_q     <= 5'd0;
      epc_r      <= 32'd0;
      redir_pc_r <= 32'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= hw_int;
      sync2_q <= sync1_q;

      // Software IP bits are written even when an entry happens this edge.
      if (cause_we) ip_sw_q <= mtc0_data[9:8];

      if (entry) begin
        // Delay-slot instructions resume at the branch (wraps modulo 2^32).
        epc_r      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_q       <= exc_bd;
        code_q     <= take_exc ? exc_code : 5'd0;
        redir_pc_r <= EXC_VECTOR;
      end else begin
        if (epc_we)    epc_r      <= mtc0_data;
        if (take_eret) redir_pc_r <= epc_r;
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] status_q;
  logic [31:0] status_d;
  logic        status_fwd;
  logic [5:0]  hw_int;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        mem_valid;
  logic        eret;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] mfc0_data;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fails  = 0;

  cp0_exc_ctrl #(.EXC_VECTOR(32'h0000_0180), .HW_INT_W(6)) dut (
    .clk(clk), .rst(rst),
    .status_q(status_q), .status_d(status_d), .status_fwd(status_fwd),
    .hw_int(hw_int), .exc_req(exc_req), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .mem_valid(mem_valid), .eret(eret),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_data(mtc0_data),
    .mfc0_data(mfc0_data), .cause_q(cause_q), .epc_q(epc_q),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Interrupt lines become visible in Cause two edges after they are
  // sampled: a two-entry delay queue whose head is what Cause shows.
  logic [5:0]  m_hw_q[$];
  logic [31:0] m_epc;
  logic        m_bd;
  logic [4:0]  m_code;
  logic [1:0]  m_sw;
  logic [31:0] m_rpc;
  bit          m_busy;

  task automatic model_reset();
    m_hw_q = '{6'd0, 6'd0};
    m_epc  = 32'd0;
    m_bd   = 1'b0;
    m_code = 5'd0;
    m_sw   = 2'b00;
    m_rpc  = 32'd0;
    m_busy = 1'b0;
  endtask

  function automatic logic [7:0] m_ip();
    return ({2'b00, m_hw_q[0]} << 2) | {6'd0, m_sw};
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = 32'd0;
    if (m_bd) c = c + 32'h8000_0000;
    c = c + ({24'd0, m_ip()} * 32'd256);
    c = c + ({27'd0, m_code} * 32'd4);
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs mid-cycle against the
  // model, advance the model at the edge, then check registered state.
  task automatic cycle();
    logic [31:0] sd, mf;
    bit pend, ent, isint, er;
    @(negedge clk);
    pend = ((m_ip() & status_q[15:8]) != 8'd0) && status_q[0] && !status_q[1] && !status_q[2];
    ent = 0; isint = 0; er = 0;
    if (!m_busy) begin
      if (exc_req) ent = 1;
      else if (pend && mem_valid) begin ent = 1; isint = 1; end
      else if (eret) er = 1;
    end
    sd = status_q;
    if (ent) sd = status_q | 32'h2;
    else if (er) sd = status_q[2] ? (status_q & ~32'h4) : (status_q & ~32'h2);
    case (cp0_addr)
      5'd12:   mf = status_q;
      5'd13:   mf = m_cause();
      5'd14:   mf = m_epc;
      default: mf = 32'd0;
    endcase
    check("status_fwd", {31'd0, status_fwd}, {31'd0, ent || er});
    check("status_d", status_d, sd);
    check("mfc0_data", mfc0_data, mf);

    @(posedge clk);
    if (ent) begin
      m_epc  = exc_bd ? exc_pc - 32'd4 : exc_pc;
      m_bd   = exc_bd;
      m_code = isint ? 5'd0 : exc_code;
      m_rpc  = 32'h0000_0180;
    end else if (er) begin
      m_rpc = m_epc;
    end
    if (mtc0_we && cp0_addr == 5'd13) m_sw = mtc0_data[9:8];
    if (mtc0_we && cp0_addr == 5'd14 && !ent) m_epc = mtc0_data;
    m_busy = ent || er;
    m_hw_q.push_back(hw_int);
    m_hw_q.delete(0);

    #1;
    check("cause_q", cause_q, m_cause());
    check("epc_q", epc_q, m_epc);
    check("flush", {31'd0, flush}, {31'd0, m_busy});
    check("redirect", {31'd0, redirect}, {31'd0, m_busy});
    check("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic idle_inputs();
    exc_req = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; mem_valid = 0;
    eret = 0; mtc0_we = 0; cp0_addr = 0; mtc0_data = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0;
    status_q = 32'h0000_FF01;
    hw_int = 6'd0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst cause_q", cause_q, 32'd0);
    check("rst epc_q", epc_q, 32'd0);
    check("rst flush", {31'd0, flush}, 32'd0);
    check("rst redirect", {31'd0, redirect}, 32'd0);
    check("rst redirect_pc", redirect_pc, 32'd0);
    check("rst status_d", status_d, 32'h0000_FF01);
    rst = 1'b1;

    // Synchronous exception entry.
    exc_req = 1; exc_code = 5'd4; exc_pc = 32'h0040_0010; exc_bd = 0;
    cycle();
    check("exc epc", epc_q, 32'h0040_0010);
    check("exc code", {27'd0, cause_q[6:2]}, 32'd4);
    check("exc flush", {31'd0, flush}, 32'd1);
    check("exc rpc", redirect_pc, 32'h0000_0180);
    exc_req = 0; status_q = 32'h0000_FF03;
    cycle();
    check("exc flush drop", {31'd0, flush}, 32'd0);

    // Interrupt through the synchronizer, delay-slot EPC.
    status_q = 32'h0000_FF01; mem_valid = 1; exc_pc = 32'h0040_0020; exc_bd = 1;
    hw_int = 6'b000001;
    cycle();
    check("int ip edge1", {31'd0, cause_q[10]}, 32'd0);
    cycle();
    check("int ip edge2", {31'd0, cause_q[10]}, 32'd1);
    cycle();
    check("int epc", epc_q, 32'h0040_001C);
    check("int bd", {31'd0, cause_q[31]}, 32'd1);
    check("int code", {27'd0, cause_q[6:2]}, 32'd0);
    status_q = 32'h0000_FF03;
    cycle();

    // Masking: IE=0, EXL=1, IM[2]=0.
    status_q = 32'h0000_FF00; cycle();
    check("mask ie flush", {31'd0, flush}, 32'd0);
    status_q = 32'h0000_FF03; cycle();
    status_q = 32'h0000_FB01; cycle();
    check("mask im flush", {31'd0, flush}, 32'd0);
    check("mask ip pend", {31'd0, cause_q[10]}, 32'd1);

    // ERET with EXL, then with ERL.
    hw_int = 0; mem_valid = 0; exc_bd = 0; status_q = 32'h0000_FF03;
    mtc0_we = 1; cp0_addr = 5'd14; mtc0_data = 32'h0040_0010;
    cycle();
    mtc0_we = 0; cp0_addr = 5'd12; eret = 1;
    cycle();
    check("eret rpc", redirect_pc, 32'h0040_0010);
    eret = 0; cycle();
    eret = 1; status_q = 32'h0000_FF07;
    #1 check("eret erl status_d", status_d, 32'h0000_FF03);
    cycle();
    eret = 0; cycle();

    // Back-to-back exception with a simultaneous Cause write.
    exc_req = 1; exc_code = 5'd8; exc_pc = 32'h0040_0100;
    mtc0_we = 1; cp0_addr = 5'd13; mtc0_data = 32'h0000_0300;
    cycle();
    check("b2b ip sw", {30'd0, cause_q[9:8]}, 32'd3);
    check("b2b epc", epc_q, 32'h0040_0100);
    mtc0_we = 0;
    cycle();
    check("b2b single entry", {31'd0, flush}, 32'd0);

    // EPC wrap, then asynchronous reset in the middle of FLUSH.
    exc_pc = 32'd0; exc_bd = 1;
    cycle();
    check("wrap epc", epc_q, 32'hFFFF_FFFC);
    idle_inputs();
    rst = 1'b0;
    #1;
    check("async rst flush", {31'd0, flush}, 32'd0);
    check("async rst redirect", {31'd0, redirect}, 32'd0);
    check("async rst cause", cause_q, 32'd0);
    check("async rst epc", epc_q, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      status_q = $urandom;
      if ($urandom_range(0, 1) == 0) status_q[2:0] = 3'b001;
      if ($urandom_range(0, 5) == 0) hw_int = 6'($urandom);
      exc_req   = ($urandom_range(0, 7) == 0);
      exc_code  = 5'($urandom);
      exc_pc    = $urandom;
      exc_bd    = 1'($urandom);
      mem_valid = 1'($urandom);
      eret      = ($urandom_range(0, 5) == 0);
      mtc0_we   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       cp0_addr = 5'd12;
        1:       cp0_addr = 5'd13;
        2:       cp0_addr = 5'd14;
        default: cp0_addr = 5'($urandom);
      endcase
      mtc0_data = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
CP0 exception/interrupt controller for the pipelined MIPS core; sits directly upstream of the CP0 Status register and produces its next-value bus (D) and forward strobe. It arbitrates synchronous exceptions, external interrupts and ERET from the MEM stage, and owns the Cause and EPC registers. It also drives the pipeline flush and PC redirect, and provides the mfc0 read mux.

Parameters:
EXC_VECTOR, 32'h0000_0180, redirect target on exception/interrupt entry
HW_INT_W, 6, number of external interrupt lines (Cause.IP[7:2])

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset
status_q  in  32  current Status (IE=[0], EXL=[1], ERL=[2], IM=[15:8])
status_d  out  32  next Status value to Status register D
status_fwd  out  1  Status forward strobe: load status_d this edge
hw_int  in  HW_INT_W  asynchronous external interrupt lines
exc_req  in  1  MEM-stage synchronous exception request
exc_code  in  5  ExcCode for exc_req
exc_pc  in  32  PC of the MEM-stage instruction
exc_bd  in  1  MEM-stage instruction is in a delay slot
mem_valid  in  1  MEM stage holds a valid, interruptible instruction
eret  in  1  MEM-stage ERET
mtc0_we  in  1  mtc0 write
cp0_addr  in  5  mtc0/mfc0 register number (12 Status, 13 Cause, 14 EPC)
mtc0_data  in  32  mtc0 write data
mfc0_data  out  32  mfc0 read data
cause_q  out  32  Cause register
epc_q  out  32  EPC register
flush  out  1  flush IF..MEM, registered
redirect  out  1  PC redirect valid, registered
redirect_pc  out  32  PC redirect target

Behaviour:
- Reset (rst=0, async): cause_q=0, epc_q=0, flush=0, redirect=0, redirect_pc=0, synchronizer flops=0, state=IDLE.
- hw_int passes a 2-flop synchronizer; sync output drives Cause.IP[7:2] (bits [15:10]) every cycle. Interrupt reaches Cause 2 edges after assertion.
- Cause layout: [31]=BD, [15:8]=IP, [6:2]=ExcCode, all other bits 0. mtc0 to 13 writes only IP[1:0] (bits [9:8]). mtc0 to 14 writes all of EPC. mtc0 to 12 ignored here (Status owns its write).
- int_pend = |(Cause.IP & status_q[15:8]) & IE & ~EXL & ~ERL.
- States: IDLE, FLUSH. Events are evaluated only in IDLE. In FLUSH all requests are ignored; FLUSH always returns to IDLE after 1 cycle.
- Priority in IDLE: exc_req > (int_pend & mem_valid) > eret.
- Entry (exc or int), same cycle, combinational: status_fwd=1, status_d=status_q|32'h2.
- Entry, at that edge: EPC<=exc_bd ? exc_pc-4 : exc_pc; BD<=exc_bd; ExcCode<=exc_code, or 0 for interrupt; state<=FLUSH; redirect_pc<=EXC_VECTOR.
- ERET, same cycle: status_fwd=1. status_d=status_q with ERL cleared if ERL=1, else with EXL cleared.
- ERET, at that edge: redirect_pc<=epc_q; state<=FLUSH.
- flush=redirect=1 exactly while state=FLUSH (1 cycle, 1 cycle after the event).
- No event: status_fwd=0, status_d=status_q (Status reloads D every cycle, so D must mirror Q).
- Simultaneous mtc0 to Cause/EPC and entry: entry wins for EPC, BD and ExcCode. The mtc0 IP[1:0] write still applies.
- mfc0_data is combinational by cp0_addr: 12 -> status_q, 13 -> cause_q, 14 -> epc_q, else 0.
- exc_pc-4 is modulo 2^32 (0 -> 32'hFFFF_FFFC).

Test Plan:
- Reset mid-FLUSH: drop rst while flush=1 -> flush, redirect, cause_q, epc_q all 0 immediately, without waiting for a clock edge.
- exc_req, code 5'd4, exc_pc=32'h0040_0010, bd=0, status_q=32'h0000_FF01:
  - same cycle: status_fwd=1, status_d=32'h0000_FF03
  - next cycle: epc_q=32'h0040_0010, cause_q[6:2]=4, flush=redirect=1, redirect_pc=32'h180
  - cycle after: flush=0
- hw_int[0] rises, IM=FF, IE=1, mem_valid=1, exc_pc=32'h0040_0020, bd=1 -> cause_q[10]=1 after 2 edges; int taken next cycle: epc_q=32'h0040_001C, cause_q[31]=1, ExcCode=0.
- Masking: same as above with IE=0 (or EXL=1, or IM[2]=0) -> no status_fwd and no flush, Cause.IP still shows pending.
- ERET, status_q=32'h0000_FF03, epc_q=32'h0040_0010 -> status_d=32'h0000_FF01; next cycle redirect_pc=32'h0040_0010. Repeat with ERL=1 (status_q=32'h0000_FF07) -> status_d=32'h0000_FF03.
- Back-to-back: exc_req held for 2 cycles -> exactly one entry, second cycle ignored in FLUSH; mtc0 to 13 with data 32'h300 same cycle as entry -> IP[1:0]=2'b11, EPC from exception.
